// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the MAR/MDR memory port with programmable wait states.
// Define MEM_WPROT_EN to make writes below PROT_LIMIT complete without modifying the array, flagged by mem_err.
module mem_responder #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 9,
   parameter int WAIT_STATES = 2,
   parameter int PROT_LIMIT  = 64
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              mem_busy,
   output logic              mem_err
);

   // Handshake: a request is taken when exactly one strobe is high at an edge in IDLE;
   // mem_busy stays high until the access edge, then mem_ready pulses for the single DONE cycle,
   // during which the initiator must drop its strobe.
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

   localparam logic [3:0]      WS_INIT  = 4'(WAIT_STATES);
   localparam logic [ADDR_W:0] PROT_TOP = (ADDR_W+1)'(PROT_LIMIT);
`ifdef MEM_WPROT_EN
   localparam bit PROT_EN = 1'b1;
`else
   localparam bit PROT_EN = 1'b0;
`endif

   state_t            state;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              op_write;
   logic              prot_hit;
   logic [DATA_W-1:0] mem [2**ADDR_W];

   assign prot_hit = PROT_EN && ({1'b0, addr_q} < PROT_TOP);

   always_ff @(posedge clk) begin
      if (!clr) begin
         state     <= S_IDLE;
         wait_cnt  <= 4'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         op_write  <= 1'b0;
         mem_rdata <= '0;
         mem_ready <= 1'b0;
         mem_busy  <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         mem_ready <= 1'b0;
         mem_err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mem_read && mem_write) begin
                  mem_err <= 1'b1;
               end else if (mem_read || mem_write) begin
                  addr_q   <= mem_addr;
                  wdata_q  <= mem_wdata;
                  op_write <= mem_write;
                  mem_busy <= 1'b1;
                  if (WS_INIT == 4'd0) begin
                     state <= S_ACCESS;
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= WS_INIT;
                  end
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1)
                  state <= S_ACCESS;
            end
            S_ACCESS: begin
               if (!op_write)
                  mem_rdata <= mem[addr_q];
               else if (prot_hit)
                  mem_err <= 1'b1;
               mem_busy  <= 1'b0;
               mem_ready <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // The array has no reset; a reset at the access edge suppresses the write.
   always_ff @(posedge clk) begin
      if (clr && state == S_ACCESS && op_write && !prot_hit)
         mem[addr_q] <= wdata_q;
   end

endmodule
